// File: rtl/nios_pio_ext.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear, synchronised inputs
// with edge capture, masked level interrupt and registered (latency 1) read data.
module nios_pio_ext #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter logic [31:0] DIR_RESET   = 32'd0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       prime_q, prime_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_d;

  logic             wr_s;
  logic             primed_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] in_sync_s;
  logic [WIDTH-1:0] rise_s, fall_s, edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] rd_s;
  logic             unused_wdata_s;

  assign wr_s           = chipselect & ~write_n;
  assign wdata_s        = writedata[WIDTH-1:0];
  assign unused_wdata_s = ^writedata;
  assign in_sync_s      = sync_q[SYNC_STAGES-1];
  assign primed_s       = (prime_q == PRIME_DONE);
  assign rise_s         = in_sync_s & ~prev_q;
  assign fall_s         = ~in_sync_s & prev_q;

  // Edge selection; edges are suppressed until the synchroniser has flushed after reset.
  always_comb begin
    edge_s = '0;
    case (EDGE_TYPE)
      0:       edge_s = rise_s;
      1:       edge_s = fall_s;
      2:       edge_s = rise_s | fall_s;
      default: edge_s = rise_s;
    endcase
    if (!primed_s) begin
      edge_s = '0;
    end else begin
      edge_s = edge_s;
    end
  end

  // Register-file write decode and capture update.
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr_s  = '0;
    if (wr_s) begin
      case (address)
        3'd0:    data_d = wdata_s;
        3'd1:    dir_d  = wdata_s;
        3'd2:    mask_d = wdata_s;
        3'd3:    clr_s  = wdata_s;
        3'd4:    data_d = data_q | wdata_s;
        3'd5:    data_d = data_q & ~wdata_s;
        default: data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
    // A new edge wins over a simultaneous clear of the same bit.
    cap_d   = (cap_q & ~clr_s) | edge_s;
    prime_d = primed_s ? prime_q : prime_q + 3'd1;
  end

  // Read mux from pre-write register state; upper bits zero-filled.
  always_comb begin
    rd_s = '0;
    case (address)
      3'd0:    rd_s = (dir_q & data_q) | (~dir_q & in_sync_s);
      3'd1:    rd_s = dir_q;
      3'd2:    rd_s = mask_q;
      3'd3:    rd_s = cap_q;
      default: rd_s = '0;
    endcase
    readdata_d = 32'(rd_s);
  end

  // All state, including the read register, clears asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      prev_q   <= '0;
      prime_q  <= 3'd0;
      data_q   <= RESET_VALUE[WIDTH-1:0];
      dir_q    <= DIR_RESET[WIDTH-1:0];
      mask_q   <= '0;
      cap_q    <= '0;
      readdata <= 32'd0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q   <= in_sync_s;
      prime_q  <= prime_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      readdata <= readdata_d;
    end
  end

  assign out_port = data_q;
  assign oe       = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_pio_ext.sv
// Bench for nios_pio_ext: directed scenarios plus random traffic, checked against
// a pin-history reference model for a rising-edge and an any-edge instance.
module tb_nios_pio_ext;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = 3'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = 32'd0;
  logic [W-1:0] in_port = '0;

  logic [31:0]  rd0, rd2;
  logic [W-1:0] out0, out2, oe0, oe2;
  logic         irq0, irq2;

  int n_cmp = 0;
  int n_bad = 0;

  nios_pio_ext #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
    .out_port(out0), .oe(oe0), .irq(irq0));

  nios_pio_ext #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
    .out_port(out2), .oe(oe2), .irq(irq2));

  always #5 clk = ~clk;

  // Reference model: pins[j] is the pin value seen just before edge j after reset release.
  logic [W-1:0] pins [0:8191];
  int           n;
  logic [W-1:0] m_out, m_dir, m_mask, m_cap0, m_cap2;
  logic [31:0]  m_rd0, m_rd2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pin_at(input int i);
    return (i >= 1) ? pins[i] : '0;
  endfunction

  task automatic model_reset();
    n = 0;
    m_out = '0; m_dir = '0; m_mask = '0; m_cap0 = '0; m_cap2 = '0;
    m_rd0 = 32'd0; m_rd2 = 32'd0;
  endtask

  task automatic model_step();
    logic [W-1:0] sy, pv, rise, fall, rd, wd, clr;
    n++;
    pins[n] = in_port;
    sy   = pin_at(n - S);
    pv   = pin_at(n - S - 1);
    rise = (n >= S + 2) ? (sy & ~pv) : '0;
    fall = (n >= S + 2) ? (~sy & pv) : '0;
    rd = '0;
    case (address)
      3'd0:    rd = (m_dir & m_out) | (~m_dir & sy);
      3'd1:    rd = m_dir;
      3'd2:    rd = m_mask;
      default: rd = '0;
    endcase
    m_rd0 = (address == 3'd3) ? 32'(m_cap0) : 32'(rd);
    m_rd2 = (address == 3'd3) ? 32'(m_cap2) : 32'(rd);
    wd  = writedata[W-1:0];
    clr = '0;
    if (chipselect && !write_n) begin
      case (address)
        3'd0:    m_out = wd;
        3'd1:    m_dir = wd;
        3'd2:    m_mask = wd;
        3'd3:    clr = wd;
        3'd4:    m_out = m_out | wd;
        3'd5:    m_out = m_out & ~wd;
        default: ;
      endcase
    end
    m_cap0 = (m_cap0 & ~clr) | rise;
    m_cap2 = (m_cap2 & ~clr) | rise | fall;
  endtask

  task automatic compare_all();
    check("out0", 32'(out0), 32'(m_out));
    check("oe0", 32'(oe0), 32'(m_dir));
    check("out2", 32'(out2), 32'(m_out));
    check("oe2", 32'(oe2), 32'(m_dir));
    check("irq0", 32'(irq0), 32'(|(m_cap0 & m_mask)));
    check("irq2", 32'(irq2), 32'(|(m_cap2 & m_mask)));
    check("rd0", rd0, m_rd0);
    check("rd2", rd2, m_rd2);
  endtask

  task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic [W-1:0] pin);
    @(negedge clk);
    address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = pin;
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic wr_cyc(input logic [2:0] a, input logic [31:0] wd, input logic [W-1:0] pin);
    cyc(a, 1'b1, 1'b0, wd, pin);
  endtask

  task automatic rd_cyc(input logic [2:0] a, input logic [W-1:0] pin);
    cyc(a, 1'b0, 1'b1, 32'd0, pin);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic do_reset(input logic [W-1:0] pin);
    @(negedge clk);
    reset_n = 1'b0; in_port = pin; chipselect = 1'b0; write_n = 1'b1;
    model_reset();
    #1;
    check("rst_out", 32'(out0), 32'd0);
    check("rst_oe", 32'(oe0), 32'd0);
    check("rst_irq", 32'(irq0), 32'd0);
    check("rst_rd", rd0, 32'd0);
    release_reset();
  endtask

  initial begin
    do_reset('0);
    for (int a = 0; a < 8; a++) rd_cyc(3'(a), 8'h00);

    // Output register, set and clear
    wr_cyc(3'd1, 32'h0000_00FF, 8'h00);
    wr_cyc(3'd0, 32'h0000_00A5, 8'h00);
    check("data_wr", 32'(out0), 32'h0000_00A5);
    wr_cyc(3'd4, 32'h0000_000A, 8'h00);
    check("outset", 32'(out0), 32'h0000_00AF);
    wr_cyc(3'd5, 32'h0000_0081, 8'h00);
    check("outclr", 32'(out0), 32'h0000_002E);
    rd_cyc(3'd0, 8'h00);
    check("data_rd", rd0, 32'h0000_002E);

    // Mixed direction read-back and upper writedata bits
    wr_cyc(3'd1, 32'h0000_000F, 8'hC0);
    wr_cyc(3'd0, 32'h0000_0033, 8'hC0);
    rd_cyc(3'd0, 8'hC0);
    check("mixed_rd", rd0, 32'h0000_00C3);
    wr_cyc(3'd0, 32'hFFFF_FF00, 8'hC0);
    check("wide_wr", 32'(out0), 32'h0000_0000);
    rd_cyc(3'd0, 8'hC0);
    check("upper_zero", rd0 >> 8, 32'd0);

    // Rising edge capture, interrupt and clear
    repeat (3) rd_cyc(3'd7, 8'h00);
    wr_cyc(3'd3, 32'h0000_00FF, 8'h00);
    wr_cyc(3'd2, 32'h0000_0001, 8'h00);
    rd_cyc(3'd7, 8'h01);
    rd_cyc(3'd7, 8'h01);
    check("irq_early", 32'(irq0), 32'd0);
    rd_cyc(3'd7, 8'h01);
    check("irq_set", 32'(irq0), 32'd1);
    wr_cyc(3'd3, 32'h0000_0001, 8'h01);
    check("irq_clr", 32'(irq0), 32'd0);
    repeat (4) rd_cyc(3'd3, 8'h00);
    check("fall_ignored", rd0, 32'd0);
    check("fall_irq", 32'(irq0), 32'd0);

    // Clear and new edge on the same bit in the same cycle
    wr_cyc(3'd3, 32'h0000_00FF, 8'h00);
    rd_cyc(3'd7, 8'h08);
    rd_cyc(3'd7, 8'h08);
    wr_cyc(3'd3, 32'h0000_0008, 8'h08);
    rd_cyc(3'd3, 8'h08);
    check("clr_vs_edge", 32'(rd0[3]), 32'd1);

    // Reset mid-way through an OUTSET write
    wr_cyc(3'd2, 32'h0000_00FF, 8'h08);
    wr_cyc(3'd0, 32'h0000_0011, 8'h08);
    repeat (3) rd_cyc(3'd7, 8'hF8);
    check("irq_pre_rst", 32'(irq0), 32'd1);
    @(negedge clk);
    address = 3'd4; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h0000_00F0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out0), 32'd0);
    check("mid_rst_irq", 32'(irq0), 32'd0);
    check("mid_rst_rd", rd0, 32'd0);
    model_reset();
    chipselect = 1'b0; write_n = 1'b1;
    release_reset();
    rd_cyc(3'd4, 8'hF8);

    // Pins high through reset release on the any-edge instance
    do_reset(8'hFF);
    repeat (12) rd_cyc(3'd3, 8'hFF);
    check("prime_cap2", rd2, 32'd0);
    check("prime_irq2", 32'(irq2), 32'd0);

    // Random traffic
    do_reset('0);
    wr_cyc(3'd2, 32'(W'($urandom)), 8'h00);
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] pin;
      pin = ($urandom_range(0, 3) == 0) ? W'($urandom) : in_port;
      cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, pin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios_pio_ext.md
Name: nios_pio_ext

Overview:
- Parametrised Avalon-MM general-purpose I/O slave for the Nios II system; next generation of the single-bit output PIO.
- Adds:
  - WIDTH-bit data path with per-bit direction and output enable.
  - Atomic set/clear output registers.
  - Synchronised inputs with edge capture.
  - Masked, level-type interrupt to the CPU.
  - Registered read data with read latency 1.

Parameters:
- WIDTH, 8: number of I/O bits, legal 1..32.
- RESET_VALUE, 0: reset value of the output data register, WIDTH bits.
- DIR_RESET, 0: reset value of the direction register (1 = output), WIDTH bits.
- EDGE_TYPE, 0: edge that sets capture bits; 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: input synchroniser depth, legal 2..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  3  word address of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable; equals direction register.
- irq  out  1  interrupt request, active-high, level.

Behaviour:
- Reset value is applied while reset_n = 0, asynchronously:
  - data_out = RESET_VALUE, direction = DIR_RESET.
  - irqmask = 0, edgecapture = 0.
  - All synchroniser and in_prev flops = 0.
  - readdata = 0, irq = 0, prime counter = 0.
- Register map (wr = chipselect & ~write_n):
  - 0 DATA: write loads data_out. Read bit i = direction[i] ? data_out[i] : in_sync[i].
  - 1 DIR: read/write direction.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read captured edges; writing 1 to a bit clears it, writing 0 leaves it unchanged.
  - 4 OUTSET: write sets data_out bits where writedata = 1; reads 0.
  - 5 OUTCLR: write clears data_out bits where writedata = 1; reads 0.
  - 6, 7: reads 0, writes ignored.
- Write timing: writes take effect at the clock edge where wr is high; out_port/oe change after that edge.
- Read timing: readdata is registered every cycle from the current address (chipselect not required). Data for address presented at edge k appears after edge k; read latency = 1.
  - A read of DATA coincident with a DATA write returns the pre-write value.
- Input path: in_port → SYNC_STAGES flop chain → in_sync; in_prev = in_sync delayed one clock.
  - rise = in_sync & ~in_prev, fall = ~in_sync & in_prev; edge selected per EDGE_TYPE.
  - A pin change before edge k sets the capture bit at edge k+SYNC_STAGES.
- Capture applies to all bits regardless of direction.
  - next_edgecapture = (edgecapture & ~clear_mask) | edge.
  - A simultaneous clear and new edge on the same bit leaves the bit set.
- Prime counter:
  - Counts 0..SYNC_STAGES+1 after reset release, then saturates.
  - The edge vector is forced to 0 until saturation, so pins already high at reset release create no capture.
- irq = |(edgecapture & irqmask), combinational from registers.
  - Deasserts in the cycle after the clearing write or the masking write.
- Reset asserted mid-operation returns all state to reset values immediately; no partial writes survive.

Test Plan:
- Reset, defaults WIDTH=8: read addresses 0..7 → DATA = in_sync (DIR = 0), others 0; out_port = 0x00, oe = 0x00, irq = 0.
- Write DIR = 0xFF, DATA = 0xA5; OUTSET 0x0A; OUTCLR 0x81 → out_port 0xA5, 0xAF, 0x2E in successive cycles; DATA reads 0x2E one cycle after address presented.
- Write DIR = 0x0F, DATA = 0x33, drive in_port = 0xC0 → DATA reads 0xC3; writedata 0xFFFFFF00 to DATA → out_port 0x00, readdata[31:8] = 0.
- EDGE_TYPE = 0, IRQMASK = 0x01, in_port[0] 0→1 before edge k → EDGECAP bit 0 set at edge k+2, irq high; write EDGECAP 0x01 → irq low next cycle; 1→0 transition → no capture.
- Clear write to EDGECAP bit 3 in the same cycle a rising edge reaches bit 3 → bit 3 remains 1.
- in_port = 0xFF held through reset release, EDGE_TYPE = 2 → EDGECAP stays 0x00, irq stays 0.
- Assert reset_n low mid-way through an OUTSET write → out_port = RESET_VALUE, irq = 0 asynchronously.
